// File: rtl/ib_div_pkg.sv
// Shared definitions for the 16/8 unsigned restoring divider.
//   N_W, D_W, CNT_W : dividend, divisor and step-counter widths
//   state_e         : controller states
//   Q_DZ, R_DZ      : quotient/remainder presented after a divide by zero
package ib_div_pkg;

  localparam int unsigned N_W   = 16;
  localparam int unsigned D_W   = 8;
  localparam int unsigned CNT_W = 5;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  localparam logic [N_W-1:0] Q_DZ = 16'hFFFF;
  localparam logic [D_W-1:0] R_DZ = 8'hFF;

  // First step processes the dividend MSB.
  localparam logic [CNT_W-1:0] CNT_FIRST = CNT_W'(N_W - 1);

endpackage

// File: rtl/ib_div_step.sv
// One combinational restoring-division iteration.
//   rem      : current remainder (D_W bits)
//   next_bit : next dividend bit, shifted in at the LSB
//   divisor  : divisor
//   next_rem : remainder after the conditional subtract
//   q_bit    : quotient bit produced by this iteration
module ib_div_step
  import ib_div_pkg::*;
(
  input  logic [D_W-1:0] rem,
  input  logic           next_bit,
  input  logic [D_W-1:0] divisor,
  output logic [D_W-1:0] next_rem,
  output logic           q_bit
);

  logic [D_W:0] partial;
  logic [D_W:0] diff;

  always_comb begin
    partial = {rem, next_bit};
    diff    = partial - {1'b0, divisor};
    q_bit   = (partial >= {1'b0, divisor});
    // When the subtract happens the result is below the divisor, so it fits in D_W bits;
    // when it does not, partial < divisor <= 255 so its top bit is already zero.
    next_rem = q_bit ? diff[D_W-1:0] : partial[D_W-1:0];
  end

endmodule

// File: rtl/ib_div_16x8_s1.sv
// Sequential 16-bit by 8-bit unsigned restoring divider, one quotient bit per clock.
//   i_clk   : clock, rising edge
//   i_nrst  : synchronous active-low reset
//   i_start : start request, operands sampled on the same edge (ignored while busy)
//   i_n/i_d : dividend / divisor
//   o_q/o_r : quotient / remainder of the last completed operation
//   o_dz    : last completed operation had a zero divisor
//   o_busy  : division in progress
//   o_done  : one-cycle completion pulse
module ib_div_16x8_s1
  import ib_div_pkg::*;
(
  input  logic           i_clk,
  input  logic           i_nrst,
  input  logic           i_start,
  input  logic [N_W-1:0] i_n,
  input  logic [D_W-1:0] i_d,
  output logic [N_W-1:0] o_q,
  output logic [D_W-1:0] o_r,
  output logic           o_dz,
  output logic           o_busy,
  output logic           o_done
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_W-1:0]   n_q, n_d;
  logic [D_W-1:0]   d_q, d_d;
  logic [D_W-1:0]   rem_q, rem_d;
  logic [N_W-1:0]   qacc_q, qacc_d;
  logic [N_W-1:0]   q_q, q_d;
  logic [D_W-1:0]   r_q, r_d;
  logic             dz_q, dz_d;

  logic [D_W-1:0]   step_rem;
  logic             step_q;

  ib_div_step u_step (
    .rem      (rem_q),
    .next_bit (n_q[cnt_q[CNT_W-2:0]]),
    .divisor  (d_q),
    .next_rem (step_rem),
    .q_bit    (step_q)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    d_d     = d_q;
    rem_d   = rem_q;
    qacc_d  = qacc_q;
    q_d     = q_q;
    r_d     = r_q;
    dz_d    = dz_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (i_start) begin
          state_d = RUN;
          cnt_d   = CNT_FIRST;
          n_d     = i_n;
          d_d     = i_d;
          rem_d   = '0;
          qacc_d  = '0;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        rem_d  = step_rem;
        qacc_d = {qacc_q[N_W-2:0], step_q};
        if (cnt_q == '0) begin
          state_d = DONE;
          // Results are only published here so they stay frozen for the whole operation.
          if (d_q == '0) begin
            q_d  = Q_DZ;
            r_d  = R_DZ;
            dz_d = 1'b1;
          end else begin
            q_d  = {qacc_q[N_W-2:0], step_q};
            r_d  = step_rem;
            dz_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      n_q     <= '0;
      d_q     <= '0;
      rem_q   <= '0;
      qacc_q  <= '0;
      q_q     <= '0;
      r_q     <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      d_q     <= d_d;
      rem_q   <= rem_d;
      qacc_q  <= qacc_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dz_q    <= dz_d;
    end
  end

  assign o_q    = q_q;
  assign o_r    = r_q;
  assign o_dz   = dz_q;
  assign o_busy = (state_q == RUN);
  assign o_done = (state_q == DONE);

endmodule

// File: tb/tb_ib_div_16x8_s1.sv
module tb_ib_div_16x8_s1;

  typedef struct packed {
    logic [15:0] q;
    logic [7:0]  r;
    logic        dz;
  } exp_t;

  logic        clk;
  logic        nrst;
  logic        start;
  logic [15:0] n;
  logic [7:0]  d;
  logic [15:0] q;
  logic [7:0]  r;
  logic        dz;
  logic        busy;
  logic        done;

  int   tests;
  int   fails;
  exp_t sb[$];

  ib_div_16x8_s1 dut (
    .i_clk   (clk),
    .i_nrst  (nrst),
    .i_start (start),
    .i_n     (n),
    .i_d     (d),
    .o_q     (q),
    .o_r     (r),
    .o_dz    (dz),
    .o_busy  (busy),
    .o_done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input logic [15:0] nn, input logic [7:0] dd);
    exp_t e;
    logic [15:0] rr;
    if (dd == 8'd0) begin
      e.q  = 16'hFFFF;
      e.r  = 8'hFF;
      e.dz = 1'b1;
    end else begin
      e.q  = nn / {8'd0, dd};
      rr   = nn % {8'd0, dd};
      e.r  = rr[7:0];
      e.dz = 1'b0;
    end
    return e;
  endfunction

  // Drive a one-cycle start and record the expected result.
  task automatic start_op(input logic [15:0] nn, input logic [7:0] dd);
    sb.push_back(model(nn, dd));
    @(negedge clk);
    n     = nn;
    d     = dd;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Count negedges after the start edge until o_done is seen; lat = edge index that samples it.
  task automatic wait_done(output int lat, output bit ok);
    ok  = 1'b0;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done) begin
        lat = i;
        ok  = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    nrst  = 1'b0;
    start = 1'b0;
    n     = '0;
    d     = '0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({q, r, dz, busy, done} !== 27'd0) begin
      fails++;
      $display("FAIL reset_outputs: got q=%h r=%h dz=%b busy=%b done=%b want all zero",
               q, r, dz, busy, done);
    end
    @(negedge clk);
    nrst = 1'b1;
  endtask

  task automatic test_directed();
    logic [15:0] tn[6];
    logic [7:0]  td[6];
    int lat;
    bit ok;
    exp_t e;
    tn = '{16'd1000, 16'hFFFF, 16'hFFFF, 16'd12345, 16'd0, 16'd255};
    td = '{8'd7, 8'hFF, 8'd1, 8'd0, 8'd13, 8'd16};
    for (int k = 0; k < 6; k++) begin
      start_op(tn[k], td[k]);
      tests++;
      if (busy !== 1'b1) begin
        fails++;
        $display("FAIL busy_in_run[%0d]: got %b want 1", k, busy);
      end
      wait_done(lat, ok);
      e = sb.pop_front();
      tests++;
      if (!ok || lat != 17) begin
        fails++;
        $display("FAIL latency[%0d]: got %0d (seen=%b) want 17", k, lat, ok);
      end
      tests++;
      if ({q, r, dz, busy} !== {e.q, e.r, e.dz, 1'b0}) begin
        fails++;
        $display("FAIL result n=%0d d=%0d: got q=%0d r=%0d dz=%b busy=%b want q=%0d r=%0d dz=%b busy=0",
                 tn[k], td[k], q, r, dz, busy, e.q, e.r, e.dz);
      end
      @(negedge clk);
      tests++;
      if (done !== 1'b0 || {q, r, dz} !== {e.q, e.r, e.dz}) begin
        fails++;
        $display("FAIL done_pulse_hold[%0d]: got done=%b q=%0d r=%0d want done=0 q=%0d r=%0d",
                 k, done, q, r, e.q, e.r);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] rn;
    logic [7:0]  rd;
    int lat;
    bit ok;
    exp_t e;
    for (int k = 0; k < 8; k++) begin
      rn = 16'($urandom);
      rd = (k == 3) ? 8'd0 : 8'($urandom_range(1, 255));
      start_op(rn, rd);
      wait_done(lat, ok);
      e = sb.pop_front();
      tests++;
      if (!ok || {q, r, dz} !== {e.q, e.r, e.dz}) begin
        fails++;
        $display("FAIL random n=%0d d=%0d: got q=%0d r=%0d dz=%b seen=%b want q=%0d r=%0d dz=%b",
                 rn, rd, q, r, dz, ok, e.q, e.r, e.dz);
      end
    end
  endtask

  // Previous result must stay visible for the whole run of the next operation.
  task automatic test_hold();
    logic [15:0] pq;
    logic [7:0]  pr;
    logic        pdz;
    int changes;
    int lat;
    bit ok;
    exp_t e;
    pq      = q;
    pr      = r;
    pdz     = dz;
    changes = 0;
    start_op(16'd40000, 8'd3);
    for (int i = 1; i < 17; i++) begin
      @(negedge clk);
      if ({q, r, dz} !== {pq, pr, pdz} || busy !== 1'b1) changes++;
    end
    tests++;
    if (changes != 0) begin
      fails++;
      $display("FAIL hold_during_run: got %0d cycles with changed outputs or busy low want 0", changes);
    end
    wait_done(lat, ok);
    e = sb.pop_front();
    tests++;
    if (!ok || {q, r, dz} !== {e.q, e.r, e.dz}) begin
      fails++;
      $display("FAIL hold_result: got q=%0d r=%0d seen=%b want q=%0d r=%0d", q, r, ok, e.q, e.r);
    end
  endtask

  task automatic test_ignore_start();
    int lat;
    int extra;
    bit ok;
    exp_t e;
    start_op(16'd100, 8'd3);
    repeat (4) @(negedge clk);
    n     = 16'd9;
    d     = 8'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, ok);
    e = sb.pop_front();
    tests++;
    if (!ok || lat != 12 || {q, r, dz} !== {e.q, e.r, e.dz}) begin
      fails++;
      $display("FAIL ignore_start: got q=%0d r=%0d lat=%0d seen=%b want q=%0d r=%0d lat=12",
               q, r, lat, ok, e.q, e.r);
    end
    extra = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done) extra++;
    end
    tests++;
    if (extra != 0) begin
      fails++;
      $display("FAIL single_done: got %0d extra done pulses want 0", extra);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    bit ok;
    exp_t e;
    start_op(16'd100, 8'd3);
    wait_done(lat, ok);
    e = sb.pop_front();
    tests++;
    if (!ok || {q, r} !== {e.q, e.r}) begin
      fails++;
      $display("FAIL b2b_first: got q=%0d r=%0d seen=%b want q=%0d r=%0d", q, r, ok, e.q, e.r);
    end
    // Start lands on the DONE edge.
    sb.push_back(model(16'd9, 8'd2));
    n     = 16'd9;
    d     = 8'd2;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL b2b_busy: got %b want 1", busy);
    end
    wait_done(lat, ok);
    e = sb.pop_front();
    tests++;
    if (!ok || lat != 17 || {q, r, dz} !== {e.q, e.r, e.dz}) begin
      fails++;
      $display("FAIL b2b_second: got q=%0d r=%0d lat=%0d seen=%b want q=%0d r=%0d lat=17",
               q, r, lat, ok, e.q, e.r);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_abort();
    int lat;
    int dones;
    bit ok;
    exp_t e;
    start_op(16'd1234, 8'd11);
    repeat (7) @(negedge clk);
    nrst = 1'b0;
    @(posedge clk);
    #1;
    e = sb.pop_front();
    tests++;
    if ({q, r, dz, busy, done} !== 27'd0) begin
      fails++;
      $display("FAIL reset_abort_outputs: got q=%h r=%h dz=%b busy=%b done=%b want all zero",
               q, r, dz, busy, done);
    end
    @(negedge clk);
    nrst  = 1'b1;
    dones = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done || busy) dones++;
    end
    tests++;
    if (dones != 0) begin
      fails++;
      $display("FAIL reset_abort_no_done: got %0d cycles with done/busy want 0", dones);
    end
    start_op(16'd50, 8'd5);
    wait_done(lat, ok);
    e = sb.pop_front();
    tests++;
    if (!ok || {q, r, dz} !== {e.q, e.r, e.dz}) begin
      fails++;
      $display("FAIL after_reset: got q=%0d r=%0d seen=%b want q=%0d r=%0d", q, r, ok, e.q, e.r);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_directed();
    test_random();
    test_hold();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
